// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, LS and memory-side signals around mem_arbiter.
// Handshake: a requester holds req/addr/we/wdata stable until it sees gnt=1, which means accepted this cycle.
// A granted read returns one cycle later as a single rvalid pulse with rdata.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_EN;
  logic              mem_RW;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_EN, mem_RW, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_EN, mem_RW, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (IF read-only, LS read/write) for a single-port synchronous memory.
// Default: fixed LS priority with IF anti-starvation; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  logic              if_gnt;
  logic              ls_gnt;
  logic              if_win;
  logic              contended;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_if_q, rd_if_d;
  logic              rd_ls_q, rd_ls_d;

  assign contended = bus.if_req & bus.ls_req;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr: 0 = IF first, 1 = LS first; moves to the loser after each contended grant.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    if_win   = ~rr_ptr_q;
    rr_ptr_d = rr_ptr_q;
    if (contended & ~rst) rr_ptr_d = ~rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [3:0] MAX_STARVE_C = 4'(MAX_STARVE);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Counts consecutive cycles IF was denied; at the limit IF takes the next contention.
  always_comb begin
    if_win       = (starve_cnt_q == MAX_STARVE_C);
    starve_cnt_d = 4'd0;
    if (bus.if_req & ~if_gnt) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= 4'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`endif

  always_comb begin
    if_gnt = ~rst & bus.if_req & (~bus.ls_req | if_win);
    ls_gnt = ~rst & bus.ls_req & ~if_gnt;
  end

  always_comb begin
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_rw    = bus.ls_we;
      mem_addr  = bus.ls_addr;
      mem_wdata = bus.ls_wdata;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
    end
  end

  // Owner tag for the read in flight; the memory returns data exactly one cycle later.
  always_comb begin
    rd_if_d = if_gnt;
    rd_ls_d = ls_gnt & ~bus.ls_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_if_q <= 1'b0;
      rd_ls_q <= 1'b0;
    end else begin
      rd_if_q <= rd_if_d;
      rd_ls_q <= rd_ls_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_EN    = if_gnt | ls_gnt;
  assign bus.mem_RW    = mem_rw;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rvalid = rd_if_q;
  assign bus.ls_rvalid = rd_ls_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural single-port memory, vector table, reset and contention sequences,
// and a read-return scoreboard. Covers the default build and ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic          rst;
    logic          if_req;
    logic [7:0]    if_addr;
    logic          ls_req;
    logic          ls_we;
    logic [7:0]    ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          e_if;
    logic          e_ls;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_STARVE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural memory: one access per cycle, 1-cycle read latency, rdata held when idle
  logic [DW-1:0] mem [256];
  logic [DW-1:0] mem_rdata_r;
  logic          pre_we;
  logic [7:0]    pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_EN === 1'b1) begin
      if (bus.mem_RW) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            mem_rdata_r <= mem[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = mem_rdata_r;

  // scoreboard
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_ls_q[$];
  int            exp_if_cyc[$];
  int            exp_ls_cyc[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic e_if;
    logic e_ls;
    if (cyc > 0) begin
      e_if = (exp_if_cyc.size() > 0) && (exp_if_cyc[0] == cyc - 1);
      e_ls = (exp_ls_cyc.size() > 0) && (exp_ls_cyc[0] == cyc - 1);
      chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, e_if});
      chk("ls_rvalid", {31'b0, bus.ls_rvalid}, {31'b0, e_ls});
      if (e_if) begin
        chk("if_rdata", bus.if_rdata, exp_if_q[0]);
        void'(exp_if_q.pop_front());
        void'(exp_if_cyc.pop_front());
      end
      if (e_ls) begin
        chk("ls_rdata", bus.ls_rdata, exp_ls_q[0]);
        void'(exp_ls_q.pop_front());
        void'(exp_ls_cyc.pop_front());
      end
    end
  end

  // driver
  function automatic vec_t mk(input logic r, input logic ir, input logic [7:0] ia,
                              input logic lr, input logic lw, input logic [7:0] la,
                              input logic [DW-1:0] ld, input logic ei, input logic el);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia;
    v.ls_req = lr; v.ls_we = lw; v.ls_addr = la; v.ls_wdata = ld;
    v.e_if = ei; v.e_ls = el;
    return v;
  endfunction

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst          = v.rst;
    bus.if_req   = v.if_req;
    bus.if_addr  = {24'h0, v.if_addr};
    bus.ls_req   = v.ls_req;
    bus.ls_we    = v.ls_we;
    bus.ls_addr  = {24'h0, v.ls_addr};
    bus.ls_wdata = v.ls_wdata;
    @(negedge clk);
    chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, v.e_if});
    chk("ls_gnt", {31'b0, bus.ls_gnt}, {31'b0, v.e_ls});
    chk("mem_EN", {31'b0, bus.mem_EN}, {31'b0, v.e_if | v.e_ls});
    if (v.e_ls) begin
      chk("mem_RW_ls", {31'b0, bus.mem_RW}, {31'b0, v.ls_we});
      chk("mem_addr_ls", bus.mem_addr, {24'h0, v.ls_addr});
      if (v.ls_we) chk("mem_wdata_ls", bus.mem_wdata, v.ls_wdata);
    end else if (v.e_if) begin
      chk("mem_RW_if", {31'b0, bus.mem_RW}, 32'h0);
      chk("mem_addr_if", bus.mem_addr, {24'h0, v.if_addr});
    end else begin
      chk("mem_RW_idle", {31'b0, bus.mem_RW}, 32'h0);
      chk("mem_addr_idle", bus.mem_addr, 32'h0);
      chk("mem_wdata_idle", bus.mem_wdata, 32'h0);
    end
    if (v.e_if) begin
      exp_if_q.push_back(ref_mem[v.if_addr]);
      exp_if_cyc.push_back(cyc);
    end
    if (v.e_ls && !v.ls_we) begin
      exp_ls_q.push_back(ref_mem[v.ls_addr]);
      exp_ls_cyc.push_back(cyc);
    end
    if (v.e_ls && v.ls_we) ref_mem[v.ls_addr] = v.ls_wdata;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  vec_t          tbl [11];
  logic [DW-1:0] rnd;
  logic          e_if_i;

  initial begin
    rnd = $urandom_range(32'h7fff_ffff, 1);
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,      0, 0);
    tbl[1]  = mk(0, 1, 8'h10, 0, 0, 8'h00, 32'h0,      1, 0);
    tbl[2]  = mk(0, 0, 8'h00, 1, 1, 8'h20, 32'h1234,   0, 1);
    tbl[3]  = mk(0, 0, 8'h00, 1, 0, 8'h20, 32'h0,      0, 1);
    tbl[4]  = mk(0, 1, 8'h20, 0, 0, 8'h00, 32'h0,      1, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 1, 8'h30, rnd,        0, 1);
`ifdef ARB_ROUND_ROBIN_EN
    tbl[6]  = mk(0, 1, 8'h30, 1, 0, 8'h10, 32'h0,      1, 0);
`else
    tbl[6]  = mk(0, 1, 8'h30, 1, 0, 8'h10, 32'h0,      0, 1);
`endif
    tbl[7]  = mk(0, 1, 8'h30, 0, 0, 8'h00, 32'h0,      1, 0);
    tbl[8]  = mk(0, 1, 8'h11, 1, 1, 8'h11, 32'hBEEF,   0, 1);
    tbl[9]  = mk(0, 1, 8'h11, 0, 0, 8'h00, 32'h0,      1, 0);
    tbl[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,      0, 0);

    rst          = 1'b1;
    pre_we       = 1'b0;
    pre_addr     = 8'h0;
    pre_data     = '0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = 32'h40;
    bus.ls_wdata = '0;
    preload(8'h10, 32'h0000_A5A5);
    preload(8'h40, 32'h4040_4040);

    // reset held with both requests pending: nothing may be granted
    for (int i = 0; i < 3; i++) step(mk(1, 1, 8'h10, 1, 0, 8'h40, 32'h0, 0, 0));

    // both requests held from the first cycle out of reset
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e_if_i = (i % 2 == 0);
`else
      e_if_i = (i % 5 == 4);
`endif
      step(mk(0, 1, 8'h10, 1, 0, 8'h40, 32'h0, e_if_i, ~e_if_i));
    end

    for (int i = 0; i < 11; i++) step(tbl[i]);

    // reset rises while an IF read and an LS write to the same address are pending
    step(mk(1, 1, 8'h10, 1, 1, 8'h10, 32'hDEAD, 0, 0));
    step(mk(0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 0, 0));
    chk("mem_10_kept", mem[8'h10], 32'h0000_A5A5);
    step(mk(0, 1, 8'h10, 0, 0, 8'h00, 32'h0, 1, 0));
    step(mk(0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 0, 0));
    step(mk(0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 0, 0));
    chk("exp_q_drained", exp_if_q.size() + exp_ls_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
